// File: rtl/rptr_empty_level.sv
// Read-side pointer and status block for an asynchronous FIFO.
// Keeps the binary and Gray read pointers with a wrap bit, and synchronizes
// the Gray write pointer into rclk. From these it derives empty,
// almost-empty, occupancy level and a sticky underflow flag.
module rptr_empty_level #(
  parameter int AddrWidth      = 4,
  parameter int SyncStages     = 2,
  parameter int AlmostEmptyThr = 2
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rinc,
  input  logic [AddrWidth:0]   wptr_i,
  input  logic                 rclr_err_i,
  output logic [AddrWidth-1:0] raddr_o,
  output logic [AddrWidth:0]   rptr_o,
  output logic                 rempty_o,
  output logic                 raempty_o,
  output logic [AddrWidth:0]   rlevel_o,
  output logic                 runderflow_o
);

  localparam int PtrW = AddrWidth + 1;
  localparam logic [PtrW-1:0] AeThr = PtrW'(AlmostEmptyThr);

  // Write-pointer synchronizer chain; stage SyncStages-1 is the usable copy.
  logic [PtrW-1:0] sync_q [SyncStages];

  logic [PtrW-1:0] rbin_q,     rbin_d;
  logic [PtrW-1:0] rptr_q,     rptr_d;
  logic [PtrW-1:0] rlevel_q,   rlevel_d;
  logic            rempty_q,   rempty_d;
  logic            raempty_q,  raempty_d;
  logic            runder_q,   runder_d;

  logic [PtrW-1:0] wq;
  logic [PtrW-1:0] wbin;
  logic            rd_en;

  assign wq = sync_q[SyncStages-1];

  // Shift the Gray write pointer through the synchronizer, no logic between stages.
  // NOTE: sequential state uses non-blocking (<=) so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      // NOTE: the synchronizer is a flop array, not a memory, so it is reset like any other state.
      for (int i = 0; i < SyncStages; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wptr_i;
      for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Next read pointer, Gray conversions, empty/level/underflow computation.
  always_comb begin
    // NOTE: every output of this block is assigned first so no path can infer a latch.
    rbin_d    = rbin_q;
    rptr_d    = rptr_q;
    rlevel_d  = rlevel_q;
    rempty_d  = rempty_q;
    raempty_d = raempty_q;
    runder_d  = runder_q;
    wbin      = wq;

    // A read is accepted only while the registered empty flag is low.
    rd_en  = rinc & ~rempty_q;
    rbin_d = rbin_q + {{AddrWidth{1'b0}}, rd_en};
    rptr_d = (rbin_d >> 1) ^ rbin_d;

    // Gray-to-binary of the synchronized write pointer, MSB downwards.
    for (int i = PtrW - 2; i >= 0; i--) wbin[i] = wbin[i+1] ^ wq[i];

    // Empty compares against the post-read pointer, so draining the last
    // word raises empty on the same edge the read is taken.
    rempty_d  = (rptr_d == wq);
    rlevel_d  = wbin - rbin_d;
    raempty_d = (rlevel_d <= AeThr);

    // Sticky underflow: set beats clear when both happen in one cycle.
    runder_d  = (rinc & rempty_q) | (runder_q & ~rclr_err_i);
  end

  // Read-domain state registers; reset reports an empty FIFO.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      runder_q  <= 1'b0;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rlevel_q  <= rlevel_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
      runder_q  <= runder_d;
    end
  end

  assign raddr_o      = rbin_q[AddrWidth-1:0];
  assign rptr_o       = rptr_q;
  assign rempty_o     = rempty_q;
  assign raempty_o    = raempty_q;
  assign rlevel_o     = rlevel_q;
  assign runderflow_o = runder_q;

endmodule

// File: tb/tb_rptr_empty_level.sv
// Self-checking bench for rptr_empty_level (AddrWidth=4, SyncStages=2,
// AlmostEmptyThr=2). A count-based reference model tracks words written and
// read and the two-sample lag of the write count into the read domain.
module tb_rptr_empty_level;

  logic       rclk;
  logic       rrst_n;
  logic       rinc;
  logic [4:0] wptr_i;
  logic       rclr_err_i;
  logic [3:0] raddr_o;
  logic [4:0] rptr_o;
  logic       rempty_o;
  logic       raempty_o;
  logic [4:0] rlevel_o;
  logic       runderflow_o;

  rptr_empty_level #(
    .AddrWidth      (4),
    .SyncStages     (2),
    .AlmostEmptyThr (2)
  ) dut (
    .rclk         (rclk),
    .rrst_n       (rrst_n),
    .rinc         (rinc),
    .wptr_i       (wptr_i),
    .rclr_err_i   (rclr_err_i),
    .raddr_o      (raddr_o),
    .rptr_o       (rptr_o),
    .rempty_o     (rempty_o),
    .raempty_o    (raempty_o),
    .rlevel_o     (rlevel_o),
    .runderflow_o (runderflow_o)
  );

  bit clk_run = 0;
  initial begin
    rclk = 1'b0;
    wait (clk_run);
    forever #5 rclk = ~rclk;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state: plain counters of words written and read.
  int m_wcnt, m_rcnt, m_wd1, m_wd2, m_lvl;
  bit m_empty, m_uf;
  logic [4:0] prev_rptr;

  function automatic logic [4:0] gray5(input int n);
    logic [4:0] b;
    b = 5'(n & 31);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wcnt = 0; m_rcnt = 0; m_wd1 = 0; m_wd2 = 0; m_lvl = 0;
    m_empty = 1; m_uf = 0; prev_rptr = 5'd0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_empty"}, 32'(rempty_o), 1);
    check({pfx, "_aempty"}, 32'(raempty_o), 1);
    check({pfx, "_level"}, 32'(rlevel_o), 0);
    check({pfx, "_rptr"}, 32'(rptr_o), 0);
    check({pfx, "_raddr"}, 32'(raddr_o), 0);
    check({pfx, "_uflow"}, 32'(runderflow_o), 0);
  endtask

  // One rclk cycle: drive inputs, take the edge, advance the model, compare.
  task automatic step(input bit inc, input bit clr);
    bit accepted;
    rinc       = inc;
    rclr_err_i = clr;
    wptr_i     = gray5(m_wcnt);
    @(posedge rclk);
    accepted = inc && !m_empty;
    m_uf     = (inc && m_empty) || (m_uf && !clr);
    if (accepted) m_rcnt++;
    // Words visible to the read side are those written two edges earlier.
    m_lvl   = (m_wd2 - m_rcnt) & 31;
    m_wd2   = m_wd1;
    m_wd1   = m_wcnt;
    m_empty = (m_lvl == 0);
    #1;
    check("empty", 32'(rempty_o), 32'(m_empty));
    check("aempty", 32'(raempty_o), 32'(m_lvl <= 2));
    check("level", 32'(rlevel_o), 32'(m_lvl));
    check("raddr", 32'(raddr_o), 32'(m_rcnt % 16));
    check("rptr", 32'(rptr_o), 32'(gray5(m_rcnt)));
    check("uflow", 32'(runderflow_o), 32'(m_uf));
    check("rptr_hamming", 32'($countones(rptr_o ^ prev_rptr)), accepted ? 1 : 0);
    prev_rptr = rptr_o;
  endtask

  initial begin
    rinc = 0; rclr_err_i = 0; wptr_i = '0;
    rrst_n = 1'b1;
    model_reset();

    // 1. Reset values with no clock running.
    #2 rrst_n = 1'b0;
    #2 check_reset_vals("rst");
    #2 rrst_n = 1'b1;
    clk_run = 1;

    // 2. Write visibility: three words appear after the synchronizer lag.
    m_wcnt = 3;
    step(0, 0);
    check("vis_e1_empty", 32'(rempty_o), 1);
    step(0, 0);
    check("vis_e2_empty", 32'(rempty_o), 1);
    step(0, 0);
    check("vis_e3_empty", 32'(rempty_o), 0);
    check("vis_e3_level", 32'(rlevel_o), 3);
    check("vis_e3_aempty", 32'(raempty_o), 0);

    // 3. Drain to empty.
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      check("drain_raddr", 32'(raddr_o), 32'(i + 1));
      check("drain_level", 32'(rlevel_o), 32'(2 - i));
      check("drain_aempty", 32'(raempty_o), 1);
    end
    check("drain_empty", 32'(rempty_o), 1);
    check("drain_rptr", 32'(rptr_o), 32'(5'b00010));

    // 4. Underflow set, clear, and set-wins-over-clear.
    step(1, 0);
    check("uf_set", 32'(runderflow_o), 1);
    check("uf_raddr_hold", 32'(raddr_o), 3);
    step(0, 1);
    check("uf_clr", 32'(runderflow_o), 0);
    step(1, 1);
    check("uf_set_wins", 32'(runderflow_o), 1);
    step(0, 1);

    // 5. Wrap-around: 40 more words, random writes and reads, level <= 16.
    for (int cyc = 0; cyc < 600 && m_rcnt < 43; cyc++) begin
      if (m_wcnt < 43 && (m_wcnt - m_rcnt) < 16 && $urandom_range(0, 3) != 0)
        m_wcnt++;
      step($urandom_range(0, 3) != 0, 0);
    end
    check("wrap_reads_done", 32'(m_rcnt), 43);
    check("wrap_raddr", 32'(raddr_o), 32'(43 % 16));
    check("wrap_rptr", 32'(rptr_o), 32'(gray5(43)));

    // 6. Reset mid-operation at level 5.
    m_wcnt = m_wcnt + 5;
    for (int i = 0; i < 3; i++) step(0, 0);
    check("mid_level5", 32'(rlevel_o), 5);
    step(1, 0);
    step(0, 0);
    step(1, 0);
    rinc = 1'b0;
    #3 rrst_n = 1'b0;
    #1 check_reset_vals("midrst");
    model_reset();
    wptr_i = 5'd0;
    @(negedge rclk);
    rrst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      check("post_rst_empty", 32'(rempty_o), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rptr_empty_level.md
# rptr_empty_level

Read-side pointer and status block for the asynchronous FIFO, parametrised in depth and synchronizer length. It keeps the binary and Gray read pointers with an extra wrap bit, and synchronizes the Gray write pointer into the read domain. From these it derives exact `empty`, a programmable `almost-empty`, the read-side occupancy level, and a sticky underflow error. It sits in the `rclk` domain between the FIFO memory read port and the write-domain pointer/full logic, which consumes `rptr_o`.

## Interface
- `AddrWidth`, 4: memory address width; FIFO depth is 2^AddrWidth. Legal when ≥2.
- `SyncStages`, 2: number of flops in the write-pointer synchronizer. Legal when ≥2.
- `AlmostEmptyThr`, 2: `raempty_o` is asserted while level ≤ this value. Legal range 0..2^AddrWidth-1.

Ports:
- `rclk` in 1: read clock. This is the only clock.
- `rrst_n` in 1: reset, asynchronous, active-low.
- `rinc` in 1: read request, one word per cycle.
- `wptr_i` in AddrWidth+1: Gray write pointer from the write domain, asynchronous to `rclk`.
- `rclr_err_i` in 1: clears the sticky underflow flag.
- `raddr_o` out AddrWidth: binary read address to memory.
- `rptr_o` out AddrWidth+1: registered Gray read pointer to the write domain.
- `rempty_o` out 1: FIFO empty.
- `raempty_o` out 1: FIFO almost empty.
- `rlevel_o` out AddrWidth+1: occupancy as seen from the read domain.
- `runderflow_o` out 1: sticky flag, set by a read attempt while empty.

## Operation
- **Synchronizer:** `SyncStages` flops on `wptr_i`, all reset to 0; `wq` is the last stage. There is no logic between the stages.
- **Pointers:** `rbin` is AddrWidth+1 bits.
  - `rbnext = rbin + (rinc & ~rempty)`.
  - `rgnext = (rbnext >> 1) ^ rbnext`.
  - Both are registered: `rbin <= rbnext`, `rptr <= rgnext`.
- **Outputs from pointers:** `raddr_o = rbin[AddrWidth-1:0]`. `rptr_o` is `rptr`, a flop output with no combinational path.
- **Empty:** `rempty <= (rgnext == wq)`.
- **Level:**
  - `wbin` is the Gray-to-binary conversion of `wq`.
  - `lvl_next = (wbin - rbnext)` modulo 2^(AddrWidth+1).
  - `rlevel_o <= lvl_next`; the value is not saturated.
  - `raempty_o <= (lvl_next <= AlmostEmptyThr)`.
- **Underflow:**
  - `rinc & rempty` sets `runderflow_o` on the next edge. The pointer does not move.
  - `rclr_err_i` clears the flag. If set and clear occur in the same cycle, set wins.
- **Wrap-around:** `rbin` wraps from 2^(AddrWidth+1)-1 to 0. `raddr_o` wraps every 2^AddrWidth reads. The MSB of `rbin` toggles per lap, so full and empty stay distinguishable on the write side.
- **Reset values:** `raddr_o`=0, `rptr_o`=0, `rempty_o`=1, `raempty_o`=1, `rlevel_o`=0, `runderflow_o`=0, and all synchronizer flops are 0.
- **Reset mid-operation:** all state clears immediately, without a clock edge. Data in memory is abandoned, and the write side must be reset in the same event.

## Timing
- A write-pointer change that is stable at `wptr_i` appears on `rempty_o`, `rlevel_o` and `raempty_o` at most SyncStages+1 `rclk` rising edges later.
- A read accepted in cycle N (`rinc`=1, `rempty_o`=0) updates `raddr_o`, `rptr_o`, `rlevel_o` and `raempty_o` at edge N+1.
- Reading the last word asserts `rempty_o` at that same edge N+1. Empty assertion is never late on the read side; only deassertion is delayed by the synchronizer.
- A simultaneous read and write-pointer advance is handled correctly: the level reflects both once the write advance has been synchronized.
- `rptr_o` changes by exactly one bit per accepted read and holds otherwise.
- `runderflow_o` rises at the edge after the offending `rinc` and falls at the edge after `rclr_err_i`.

## Test plan
All scenarios use AddrWidth=4, SyncStages=2 and AlmostEmptyThr=2.
1. **Reset values:** assert `rrst_n`=0 with no clock running → `rempty_o`=1, `raempty_o`=1, `rlevel_o`=0, `rptr_o`=0, `raddr_o`=0, `runderflow_o`=0.
2. **Write visibility:** after reset, drive `wptr_i`=5'b00010 (gray(3)) → after 3 edges `rempty_o`=0, `rlevel_o`=3, `raempty_o`=0; before the 3rd edge `rempty_o`=1.
3. **Drain to empty:** continuing from scenario 2, apply `rinc`=1 for 3 cycles.
   - `raddr_o` steps 0,1,2,3.
   - `rlevel_o` steps 3,2,1,0.
   - `raempty_o`=1 from the first read onward.
   - `rempty_o`=1 at the 3rd edge, with `rptr_o`=5'b00010.
4. **Underflow and clear:** with `rempty_o`=1, apply `rinc`=1 → `runderflow_o`=1 next edge and `raddr_o` unchanged.
   - `rclr_err_i` alone → flag clears.
   - `rinc`=1 together with `rclr_err_i`=1 while empty → flag stays 1.
5. **Wrap-around:** advance `wptr_i` in Gray steps through 40 words while reading continuously with level ≤16.
   - `rptr_o` has a Hamming distance of 1 per read.
   - `rbin` wraps 31→0 and `raddr_o` wraps 15→0.
   - `rlevel_o` always equals the scoreboard count after the 3-edge lag.
6. **Reset mid-operation:** with level 5 and `rinc` toggling, pulse `rrst_n` low between clock edges → all outputs return to their reset values immediately. After release and `wptr_i`=0, `rempty_o` stays 1.
